// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Watches a multiplexed, active-low 7-segment display bus and recovers the hex
// value shown on each digit. A pattern is captured once it has been held
// unchanged for STABLE_CYCLES clock edges with exactly one digit enable set.
// Each stable hold yields exactly one capture.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   seg          segment lines, active-low, seg[0]=a .. seg[6]=g
//   dig_en       digit enables, active-high, one-hot while a digit is driven
//   digits_out   decoded values, digit i at [4i+3:4i]
//   digit_valid  1 = last capture on digit i was a legal pattern
//   frame_done   one-cycle pulse when every digit has been captured since
//                the previous pulse
//   err          one-cycle pulse on capture of an illegal pattern
//   err_digit    digit index of the most recent err (holds between errors)
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    err,
    output logic [2:0]              err_digit
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SMP_W = NUM_DIGITS + 7;

    // Decode an active-low {g,f,e,d,c,b,a} pattern; bit 4 = legal, [3:0] = value.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h40:   res = 5'h10;
            7'h79:   res = 5'h11;
            7'h24:   res = 5'h12;
            7'h30:   res = 5'h13;
            7'h19:   res = 5'h14;
            7'h12:   res = 5'h15;
            7'h02:   res = 5'h16;
            7'h78:   res = 5'h17;
            7'h00:   res = 5'h18;
            7'h18:   res = 5'h19;
            7'h08:   res = 5'h1A;
            7'h03:   res = 5'h1B;
            7'h46:   res = 5'h1C;
            7'h21:   res = 5'h1D;
            7'h06:   res = 5'h1E;
            7'h0E:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    // Exactly one bit set; zero or several bits set means the bus is blanking.
    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != {NUM_DIGITS{1'b0}}) &&
               ((v & (v - {{(NUM_DIGITS-1){1'b0}}, 1'b1})) == {NUM_DIGITS{1'b0}});
    endfunction

    // Index of the set bit of a one-hot vector.
    function automatic logic [2:0] onehot_index(input logic [NUM_DIGITS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (v[k]) begin
                idx = 3'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [SMP_W-1:0]        smp_q, smp_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    armed_q, armed_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    frame_q, frame_d;
    logic                    err_q, err_d;
    logic [2:0]              err_digit_q, err_digit_d;

    logic [SMP_W-1:0]        incoming_s;
    logic                    changed_s;
    logic                    onehot_s;
    logic                    capture_s;
    logic [4:0]              dec_s;
    logic [NUM_DIGITS-1:0]   seen_or_s;

    // Stability filter, capture qualification and per-digit result update.
    always_comb begin
        incoming_s  = {dig_en, seg};
        changed_s   = (incoming_s != smp_q);
        onehot_s    = is_onehot(dig_en);
        dec_s       = seg_decode(seg);
        smp_d       = incoming_s;

        cnt_d       = cnt_q;
        armed_d     = armed_q;
        seen_d      = seen_q;
        digits_d    = digits_q;
        valid_d     = valid_q;
        frame_d     = 1'b0;
        err_d       = 1'b0;
        err_digit_d = err_digit_q;

        // cnt counts edges on which the held pattern matched the sample; the
        // capture edge is the one on which cnt would reach STABLE_CYCLES-1,
        // i.e. the STABLE_CYCLES-th edge of the hold.
        capture_s = !changed_s && onehot_s && armed_q &&
                    (cnt_q == CNT_W'(STABLE_CYCLES - 2));

        if (changed_s || !onehot_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        if (changed_s) begin
            armed_d = 1'b1;
        end else if (capture_s) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end

        // Since dig_en is one-hot on a capture, OR-ing it marks digit i as seen.
        seen_or_s = seen_q | dig_en;

        if (capture_s) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (dig_en[k]) begin
                    valid_d[k] = dec_s[4];
                    if (dec_s[4]) begin
                        digits_d[4*k +: 4] = dec_s[3:0];
                    end else begin
                        digits_d[4*k +: 4] = digits_q[4*k +: 4];
                    end
                end else begin
                    valid_d[k] = valid_q[k];
                end
            end
            if (!dec_s[4]) begin
                err_d       = 1'b1;
                err_digit_d = onehot_index(dig_en);
            end else begin
                err_d       = 1'b0;
            end
            if (&seen_or_s) begin
                frame_d = 1'b1;
                seen_d  = {NUM_DIGITS{1'b0}};
            end else begin
                seen_d  = seen_or_s;
            end
        end else begin
            seen_d = seen_q;
        end
    end

    // State and output registers; rst overrides any capture on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q       <= {SMP_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            armed_q     <= 1'b1;
            seen_q      <= {NUM_DIGITS{1'b0}};
            digits_q    <= {(4*NUM_DIGITS){1'b0}};
            valid_q     <= {NUM_DIGITS{1'b0}};
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            err_digit_q <= 3'd0;
        end else begin
            smp_q       <= smp_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            seen_q      <= seen_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_q;
    assign err         = err_q;
    assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 time
// unit after a rising edge. A pattern driven now is first seen at the next
// edge E and captured at E+3, so it is visible after tick(4).
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [15:0] digits_out;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;
    logic [2:0]  err_digit;

    int n_tests;
    int n_fail;

    logic [6:0] seg_tbl [16];
    logic [3:0] prev_val;

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .dig_en      (dig_en),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err),
        .err_digit   (err_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] de, input logic [6:0] s);
        dig_en = de;
        seg    = s;
    endtask

    // Hold a legal value on one digit for 5 edges, checking the capture edge.
    task automatic scan_digit(input int d, input logic [3:0] v, input logic exp_frame);
        drive(4'(1 << d), seg_tbl[v]);
        tick(4);
        check_val($sformatf("scan_val_d%0d", d), 32'(digits_out[4*d +: 4]), 32'(v));
        check_val($sformatf("scan_frame_d%0d", d), 32'(frame_done), 32'(exp_frame));
        tick(1);
        check_val($sformatf("scan_frame_off_d%0d", d), 32'(frame_done), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Reset with 8 on digit 0 driven throughout.
        rst = 1'b1;
        drive(4'b0001, 7'h00);
        tick(1);
        check_val("rst_digits", 32'(digits_out), 32'd0);
        check_val("rst_valid", 32'(digit_valid), 32'd0);
        check_val("rst_flags", {29'd0, frame_done, err, 1'b0}, 32'd0);
        check_val("rst_err_digit", 32'(err_digit), 32'd0);
        tick(2);
        check_val("rst_digits_hold", 32'(digits_out), 32'd0);
        check_val("rst_valid_hold", 32'(digit_valid), 32'd0);
        rst = 1'b0;
        tick(3);
        check_val("post_rst_no_cap", 32'(digit_valid), 32'd0);
        tick(1);
        check_val("post_rst_cap_valid", 32'(digit_valid), 32'h1);
        check_val("post_rst_cap_val", 32'(digits_out[3:0]), 32'h8);

        // All 16 codes on digit 0, 6-cycle hold then a 2-cycle blank gap.
        prev_val = 4'h8;
        for (int v = 0; v < 16; v++) begin
            drive(4'b0001, seg_tbl[v]);
            tick(3);
            check_val($sformatf("dec_early_%0d", v), 32'(digits_out[3:0]), 32'(prev_val));
            tick(1);
            check_val($sformatf("dec_val_%0d", v), 32'(digits_out[3:0]), 32'(v));
            check_val($sformatf("dec_valid_%0d", v), 32'(digit_valid[0]), 32'd1);
            check_val($sformatf("dec_err_%0d", v), 32'(err), 32'd0);
            tick(2);
            dig_en = 4'b0000;
            tick(2);
            prev_val = 4'(v);
        end

        // Glitch: 1 held only 3 edges, then 2 held 8 edges on digit 2.
        drive(4'b0100, 7'h79);
        tick(3);
        seg = 7'h24;
        tick(3);
        check_val("glitch_no_cap_val", 32'(digits_out[11:8]), 32'd0);
        check_val("glitch_no_cap_valid", 32'(digit_valid[2]), 32'd0);
        tick(1);
        check_val("glitch_cap_val", 32'(digits_out[11:8]), 32'd2);
        check_val("glitch_cap_valid", 32'(digit_valid[2]), 32'd1);
        tick(4);

        // Illegal blank pattern on digit 1 after it showed 7.
        drive(4'b0010, 7'h78);
        tick(4);
        check_val("ill_pre_val", 32'(digits_out[7:4]), 32'd7);
        check_val("ill_pre_valid", 32'(digit_valid[1]), 32'd1);
        tick(1);
        seg = 7'h7F;
        tick(3);
        check_val("ill_err_early", 32'(err), 32'd0);
        tick(1);
        check_val("ill_err_pulse", 32'(err), 32'd1);
        check_val("ill_err_digit", 32'(err_digit), 32'd1);
        check_val("ill_valid", 32'(digit_valid[1]), 32'd0);
        check_val("ill_val_held", 32'(digits_out[7:4]), 32'd7);
        check_val("ill_no_frame", 32'(frame_done), 32'd0);
        tick(1);
        check_val("ill_err_once", 32'(err), 32'd0);
        check_val("ill_err_digit_hold", 32'(err_digit), 32'd1);
        tick(1);

        // Frame: digits 0,1,2 already seen, so digit 3 completes the frame.
        scan_digit(0, 4'h1, 1'b0);
        scan_digit(1, 4'h2, 1'b0);
        scan_digit(2, 4'h3, 1'b0);
        scan_digit(3, 4'h4, 1'b1);
        check_val("frame_digits", 32'(digits_out), 32'h4321);
        check_val("frame_valid", 32'(digit_valid), 32'hF);
        // Repeat scan: seen was cleared, so only digit 3 pulses again.
        scan_digit(0, 4'h1, 1'b0);
        scan_digit(1, 4'h2, 1'b0);
        scan_digit(2, 4'h3, 1'b0);
        scan_digit(3, 4'h4, 1'b1);

        // Two enables at once never qualify.
        drive(4'b0110, 7'h00);
        for (int c = 0; c < 10; c++) begin
            tick(1);
            check_val($sformatf("multi_en_digits_%0d", c), 32'(digits_out), 32'h4321);
            check_val($sformatf("multi_en_err_%0d", c), 32'(err), 32'd0);
        end

        // Reset in the middle of a hold of 3 on digit 0.
        drive(4'b0001, 7'h30);
        tick(2);
        rst = 1'b1;
        tick(1);
        check_val("mid_rst_digits", 32'(digits_out), 32'd0);
        check_val("mid_rst_valid", 32'(digit_valid), 32'd0);
        rst = 1'b0;
        tick(3);
        check_val("mid_rst_no_cap", 32'(digit_valid), 32'd0);
        tick(1);
        check_val("mid_rst_cap_val", 32'(digits_out[3:0]), 32'd3);
        check_val("mid_rst_cap_valid", 32'(digit_valid), 32'h1);
        check_val("mid_rst_no_frame", 32'(frame_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
